// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam int ALU_OP_W   = 3;
    localparam int ALU_RES_W  = 7;
    localparam int ALU_DATA_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_OP_0 = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_1 = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_OP_2 = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OP_3 = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_OP_4 = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_OP_5 = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_OP_6 = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_OP_7 = 3'b111;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one ALU among N_REQ requesters: grant, issue for ALU_LAT cycles, return tagged result.
module alu_rr_sched
    import alu_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int OP_W    = ALU_OP_W,
    parameter int DATA_W  = ALU_DATA_W,
    parameter int RES_W   = ALU_RES_W,
    parameter int ALU_LAT = 1,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*OP_W-1:0]  req_op,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic [OP_W-1:0]        alu_sel,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    input  logic [RES_W-1:0]       alu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [RES_W-1:0]       rsp_data,
    output logic                   busy
);

    localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [RES_W-1:0]   rsp_data_q, rsp_data_d;

    logic [N_REQ-1:0]   gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               any;

    rr_arbiter #(.N(N_REQ), .PTR_W(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Requesters hold valid/data until accepted; the response holds until rsp_ready.
    assign req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign alu_sel   = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    op_d    = req_op[gnt_idx*OP_W +: OP_W];
                    a_d     = req_a[gnt_idx*DATA_W +: DATA_W];
                    b_d     = req_b[gnt_idx*DATA_W +: DATA_W];
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    rsp_data_d = alu_result;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched: one instance with ALU_LAT=1, one with ALU_LAT=3.
module tb_alu_rr_sched;
    import alu_sched_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    // ALU_LAT=1 instance
    logic [3:0]  valid0, ready0;
    logic [11:0] op0;
    logic [15:0] a0, b0;
    logic [2:0]  sel0;
    logic [3:0]  aa0, bb0;
    logic [6:0]  res0, rd0;
    logic        rv0, rr0, busy0;
    logic [1:0]  rid0;

    // ALU_LAT=3 instance
    logic [3:0]  valid3, ready3;
    logic [11:0] op3;
    logic [15:0] a3, b3;
    logic [2:0]  sel3;
    logic [3:0]  aa3, bb3;
    logic [6:0]  res3, rd3;
    logic        rv3, rr3, busy3;
    logic [1:0]  rid3;

    function automatic logic [6:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        logic [6:0] ea, eb;
        ea = {3'b000, a};
        eb = {3'b000, b};
        case (op)
            ALU_OP_0: return ea + eb;
            ALU_OP_1: return ea - eb;
            ALU_OP_2: return ea * eb;
            ALU_OP_3: return ea & eb;
            ALU_OP_4: return ea | eb;
            ALU_OP_5: return ea ^ eb;
            ALU_OP_6: return {1'b0, a, 2'b00};
            ALU_OP_7: return {3'b000, ~a};
            default:  return 7'd0;
        endcase
    endfunction

    assign res0 = alu_model(sel0, aa0, bb0);
    assign res3 = alu_model(sel3, aa3, bb3);

    alu_rr_sched #(.N_REQ(4), .ALU_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(ready0),
        .req_op(op0), .req_a(a0), .req_b(b0), .alu_sel(sel0), .alu_a(aa0),
        .alu_b(bb0), .alu_result(res0), .rsp_valid(rv0), .rsp_ready(rr0),
        .rsp_id(rid0), .rsp_data(rd0), .busy(busy0)
    );

    alu_rr_sched #(.N_REQ(4), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(ready3),
        .req_op(op3), .req_a(a3), .req_b(b3), .alu_sel(sel3), .alu_a(aa3),
        .alu_b(bb3), .alu_result(res3), .rsp_valid(rv3), .rsp_ready(rr3),
        .rsp_id(rid3), .rsp_data(rd3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req0(input int i, input logic [2:0] op, input logic [3:0] a,
                            input logic [3:0] b);
        op0[i*3 +: 3] = op;
        a0[i*4 +: 4]  = a;
        b0[i*4 +: 4]  = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    int exp_id[5];
    int exp_op[5];
    int exp_dat[5];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        valid0 = '0; op0 = '0; a0 = '0; b0 = '0; rr0 = 1'b1;
        valid3 = '0; op3 = '0; a3 = '0; b3 = '0; rr3 = 1'b1;

        // Reset values
        tick();
        check("rst_ready", 32'(ready0), 32'h0);
        check("rst_rsp_valid", 32'(rv0), 32'h0);
        check("rst_busy", 32'(busy0), 32'h0);
        check("rst_alu_sel", 32'(sel0), 32'h0);
        check("rst_rsp_data", 32'(rd0), 32'h0);
        rst_n = 1'b1;

        // Single request from requester 0: op2, 3*5 = 15
        set_req0(0, ALU_OP_2, 4'd3, 4'd5);
        valid0 = 4'b0001;
        #1;
        check("t1_ready", 32'(ready0), 32'h1);
        tick();
        valid0 = 4'b0000;
        #1;
        check("t1_ready_issue", 32'(ready0), 32'h0);
        check("t1_busy", 32'(busy0), 32'h1);
        check("t1_alu_sel", 32'(sel0), 32'd2);
        check("t1_alu_a", 32'(aa0), 32'd3);
        check("t1_alu_b", 32'(bb0), 32'd5);
        check("t1_rv_issue", 32'(rv0), 32'h0);
        tick();
        check("t1_rv", 32'(rv0), 32'h1);
        check("t1_rid", 32'(rid0), 32'd0);
        check("t1_rdata", 32'(rd0), 32'd15);
        tick();
        check("t1_rv_idle", 32'(rv0), 32'h0);
        check("t1_busy_idle", 32'(busy0), 32'h0);
        check("t1_sel_held", 32'(sel0), 32'd2);

        // All four valid continuously, starting from ptr=0
        do_reset();
        set_req0(0, ALU_OP_0, 4'd3, 4'd4);
        set_req0(1, ALU_OP_1, 4'd9, 4'd3);
        set_req0(2, ALU_OP_4, 4'd12, 4'd3);
        set_req0(3, ALU_OP_6, 4'd5, 4'd0);
        exp_id  = '{0, 1, 2, 3, 0};
        exp_op  = '{0, 1, 4, 6, 0};
        exp_dat = '{7, 6, 15, 20, 7};
        valid0 = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            check("t2_ready_grant", 32'(ready0), 32'(1 << exp_id[g]));
            tick();
            check("t2_ready_issue", 32'(ready0), 32'h0);
            check("t2_alu_sel", 32'(sel0), 32'(exp_op[g]));
            check("t2_rv_issue", 32'(rv0), 32'h0);
            tick();
            check("t2_ready_resp", 32'(ready0), 32'h0);
            check("t2_rv", 32'(rv0), 32'h1);
            check("t2_rid", 32'(rid0), 32'(exp_id[g]));
            check("t2_rdata", 32'(rd0), 32'(exp_dat[g]));
            tick();
        end
        valid0 = 4'b0000;

        // Backpressure: ptr=1, requester 2 wins, response held 5 cycles
        valid0 = 4'b0100;
        rr0 = 1'b0;
        #1;
        check("t3_ready_grant", 32'(ready0), 32'h4);
        tick();
        valid0 = 4'b0101;
        tick();
        check("t3_rv", 32'(rv0), 32'h1);
        check("t3_rid", 32'(rid0), 32'd2);
        check("t3_rdata", 32'(rd0), 32'd15);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_rv_hold", 32'(rv0), 32'h1);
            check("t3_rid_hold", 32'(rid0), 32'd2);
            check("t3_rdata_hold", 32'(rd0), 32'd15);
            check("t3_ready_hold", 32'(ready0), 32'h0);
        end
        rr0 = 1'b1;
        #1;
        check("t3_rv_release", 32'(rv0), 32'h1);
        tick();
        check("t3_ready_resume", 32'(ready0), 32'h1);
        check("t3_busy_idle", 32'(busy0), 32'h0);
        tick();
        valid0 = 4'b0000;
        tick();
        check("t3_rid_next", 32'(rid0), 32'd0);
        check("t3_rdata_next", 32'(rd0), 32'd7);
        tick();

        // Reset mid-ISSUE: requester 3 in flight, ptr currently 1
        valid0 = 4'b1000;
        #1;
        check("t4_ready_grant", 32'(ready0), 32'h8);
        tick();
        check("t4_busy_issue", 32'(busy0), 32'h1);
        check("t4_sel_issue", 32'(sel0), 32'd6);
        rst_n = 1'b0;
        #1;
        check("t4_async_busy", 32'(busy0), 32'h0);
        check("t4_async_sel", 32'(sel0), 32'h0);
        check("t4_async_a", 32'(aa0), 32'h0);
        check("t4_async_b", 32'(bb0), 32'h0);
        check("t4_async_rid", 32'(rid0), 32'h0);
        check("t4_async_rdata", 32'(rd0), 32'h0);
        check("t4_async_rv", 32'(rv0), 32'h0);
        check("t4_async_ready", 32'(ready0), 32'h0);
        tick();
        check("t4_no_rsp_a", 32'(rv0), 32'h0);
        tick();
        check("t4_no_rsp_b", 32'(rv0), 32'h0);
        rst_n = 1'b1;
        valid0 = 4'b1001;
        #1;
        check("t4_ptr_zero", 32'(ready0), 32'h1);
        tick();
        valid0 = 4'b1000;
        tick();
        check("t4_rid0", 32'(rid0), 32'd0);
        check("t4_rdata0", 32'(rd0), 32'd7);
        tick();
        check("t4_grant3", 32'(ready0), 32'h8);
        tick();
        valid0 = 4'b1001;
        tick();
        check("t4_rid3", 32'(rid0), 32'd3);
        check("t4_rdata3", 32'(rd0), 32'd20);
        tick();
        check("t5_wrap_grant0", 32'(ready0), 32'h1);
        tick();
        valid0 = 4'b1000;
        tick();
        check("t5_wrap_rid0", 32'(rid0), 32'd0);
        tick();
        check("t5_wrap_grant3", 32'(ready0), 32'h8);
        valid0 = 4'b0000;

        // ALU_LAT=3 instance, requester 2: op2, 7*9 = 63
        op3[2*3 +: 3] = ALU_OP_2;
        a3[2*4 +: 4]  = 4'd7;
        b3[2*4 +: 4]  = 4'd9;
        valid3 = 4'b0100;
        #1;
        check("t6_ready", 32'(ready3), 32'h4);
        tick();
        valid3 = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            check("t6_sel_held", 32'(sel3), 32'd2);
            check("t6_rv_wait", 32'(rv3), 32'h0);
            check("t6_busy", 32'(busy3), 32'h1);
            tick();
        end
        check("t6_rv", 32'(rv3), 32'h1);
        check("t6_rid", 32'(rid3), 32'd2);
        check("t6_rdata", 32'(rd3), 32'd63);
        check("t6_sel_resp", 32'(sel3), 32'd2);
        tick();
        check("t6_rv_idle", 32'(rv3), 32'h0);
        check("t6_busy_idle", 32'(busy3), 32'h0);
        check("t6_sel_idle", 32'(sel3), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
